// File: rtl/booth_radix4_mult.sv
// Radix-4 Booth sequential multiplier with built-in start/done controller.
// Two multiplier bits are retired per cycle; operands are extended by two
// bits so that signed and unsigned products share a single recoder.
module booth_radix4_mult #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     m_in,
    input  logic [WIDTH-1:0]     q_in,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    // Extended operand width, accumulator width, step count and counter width
    localparam int EW = WIDTH + 2;
    localparam int AW = WIDTH + 4;
    localparam int N  = (WIDTH + 2) / 2;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_nextState;

    logic [AW-1:0]      r_a;
    logic [EW-1:0]      r_q;
    logic [EW-1:0]      r_m;
    logic               r_qm1;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_product;

    logic [AW-1:0]      w_mExt;
    logic [AW-1:0]      w_m2;
    logic [AW-1:0]      w_addend;
    logic [AW-1:0]      w_sum;
    logic [AW-1:0]      w_nextA;
    logic [EW-1:0]      w_nextQ;
    logic               w_lastStep;
    logic               w_mSign;
    logic               w_qSign;

    // Multiplicand and its double, sign-extended to accumulator width
    assign w_mExt = {{2{r_m[EW-1]}}, r_m};
    assign w_m2   = {r_m[EW-1], r_m, 1'b0};

    // Extension bit for the incoming operands: sign bit only in signed mode
    assign w_mSign = signed_mode & m_in[WIDTH-1];
    assign w_qSign = signed_mode & q_in[WIDTH-1];

    // Booth digit selection from the two low multiplier bits and the guard bit
    always_comb begin
        w_addend = '0;
        case ({r_q[1:0], r_qm1})
            3'b001, 3'b010: w_addend = w_mExt;
            3'b011:         w_addend = w_m2;
            3'b100:         w_addend = -w_m2;
            3'b101, 3'b110: w_addend = -w_mExt;
            default:        w_addend = '0;
        endcase
    end

    // Add the selected partial product, then shift {A, Q, q_m1} right by two
    assign w_sum      = r_a + w_addend;
    assign w_nextA    = {{2{w_sum[AW-1]}}, w_sum[AW-1:2]};
    assign w_nextQ    = {w_sum[1:0], r_q[EW-1:2]};
    assign w_lastStep = (r_state == CALC) && (r_cnt == CW'(1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        w_nextState = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (r_cnt == CW'(1)) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath: load operands on an accepted start, iterate in CALC
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_q   <= '0;
            r_m   <= '0;
            r_qm1 <= 1'b0;
            r_cnt <= '0;
        end else if (r_state == IDLE && start) begin
            r_a   <= '0;
            r_q   <= {{2{w_qSign}}, q_in};
            r_m   <= {{2{w_mSign}}, m_in};
            r_qm1 <= 1'b0;
            r_cnt <= CW'(N);
        end else if (r_state == CALC) begin
            r_a   <= w_nextA;
            r_q   <= w_nextQ;
            r_qm1 <= r_q[1];
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // Result register: captured from the final shifted {A, Q} and held otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            r_product <= '0;
        end else if (w_lastStep) begin
            r_product <= {w_nextA[WIDTH-3:0], w_nextQ};
        end
    end

    assign product = r_product;

endmodule
